// File: rtl/topk_queue.sv
// Bounded top-K priority store: keeps the DEPTH best (data, tag) entries, dequeues min or max,
// and replaces the worst entry on a better insert into a full store. Optional TOPK_STATS_EN adds a drop counter.
module topk_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 32,
  parameter int DEPTH         = 8,
  parameter int KEEP_SMALLEST = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      flush_in,
  input  logic                      enq_in,
  input  logic [DATA_WIDTH-1:0]     enq_data_in,
  input  logic [TAG_WIDTH-1:0]      enq_tag_in,
  input  logic                      deq_min_in,
  input  logic                      deq_max_in,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic [TAG_WIDTH-1:0]      tag_out,
  output logic                      evict_valid_out,
  output logic [DATA_WIDTH-1:0]     evict_data_out,
  output logic [TAG_WIDTH-1:0]      evict_tag_out,
  output logic [$clog2(DEPTH):0]    size_out,
  output logic                      empty_out,
  output logic                      full_out,
  output logic [TAG_WIDTH-1:0]      min_tag_out,
  output logic [TAG_WIDTH-1:0]      max_tag_out
`ifdef TOPK_STATS_EN
  ,
  output logic [15:0]               drop_count_out
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      valid_d;
  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [IW-1:0] min_idx;
  logic [IW-1:0] max_idx;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] worst_idx;
  logic [IW-1:0] deq_idx;
  logic [IW-1:0] wr_idx;
  logic          any_valid;
  logic          better;
  logic          deq_do;
  logic          wr_en;
  logic          wr_new;
  logic          evict_do;

  // Scans over pre-edge state. Ascending order with strict compares makes ties pick the lowest slot.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    min_idx   = '0;
    max_idx   = '0;
    free_idx  = '0;
    any_valid = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (!any_valid) begin
          min_idx = IW'(i);
          max_idx = IW'(i);
        end else begin
          if (tag_q[i] < tag_q[min_idx]) min_idx = IW'(i);
          if (tag_q[i] > tag_q[max_idx]) max_idx = IW'(i);
        end
        any_valid = 1'b1;
      end
    end
  end

  assign worst_idx = (KEEP_SMALLEST != 0) ? max_idx : min_idx;
  assign better    = (KEEP_SMALLEST != 0) ? (enq_tag_in < tag_q[max_idx])
                                          : (enq_tag_in > tag_q[min_idx]);
  assign full_out  = (size_out == SW'(DEPTH));
  assign empty_out = (size_out == '0);

  assign min_tag_out = any_valid ? tag_q[min_idx] : '0;
  assign max_tag_out = any_valid ? tag_q[max_idx] : '0;

  always_comb begin
    deq_do   = (deq_min_in || deq_max_in) && any_valid && !flush_in;
    deq_idx  = deq_min_in ? min_idx : max_idx;
    wr_en    = 1'b0;
    wr_new   = 1'b0;
    wr_idx   = free_idx;
    evict_do = 1'b0;
    if (enq_in && !flush_in) begin
      if (deq_do) begin
        // Reuse the slot being freed so the store never needs a spare entry.
        wr_en  = 1'b1;
        wr_idx = deq_idx;
      end else if (!full_out) begin
        wr_en  = 1'b1;
        wr_new = 1'b1;
      end else if (better) begin
        wr_en    = 1'b1;
        wr_idx   = worst_idx;
        evict_do = 1'b1;
      end
    end

    valid_d = valid_q;
    if (flush_in) begin
      valid_d = '0;
    end else begin
      if (deq_do) valid_d[deq_idx] = 1'b0;
      if (wr_en)  valid_d[wr_idx]  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q         <= '0;
      size_out        <= '0;
      valid_out       <= 1'b0;
      data_out        <= '0;
      tag_out         <= '0;
      evict_valid_out <= 1'b0;
      evict_data_out  <= '0;
      evict_tag_out   <= '0;
    end else begin
      valid_q         <= valid_d;
      valid_out       <= deq_do;
      evict_valid_out <= evict_do;
      if (flush_in) begin
        size_out <= '0;
      end else if (wr_new) begin
        size_out <= size_out + SW'(1);
      end else if (deq_do && !wr_en) begin
        size_out <= size_out - SW'(1);
      end
      if (deq_do) begin
        data_out <= data_q[deq_idx];
        tag_out  <= tag_q[deq_idx];
      end
      if (evict_do) begin
        evict_data_out <= data_q[worst_idx];
        evict_tag_out  <= tag_q[worst_idx];
      end
    end
  end

  // NOTE: the entry storage is deliberately not reset; valid_q alone decides what is live.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= enq_tag_in;
      data_q[wr_idx] <= enq_data_in;
    end
  end

`ifdef TOPK_STATS_EN
  logic drop_do;
  assign drop_do = enq_in && !flush_in && !deq_do && full_out && !better;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_count_out <= '0;
    end else if (flush_in) begin
      drop_count_out <= '0;
    end else if (drop_do && (drop_count_out != 16'hFFFF)) begin
      drop_count_out <= drop_count_out + 16'd1;
    end
  end
`else
  // Without statistics there is no drop counter.
`endif

endmodule
